collision_pair_scheduler: RTL and testbench
===========================================

COLLISION_PAIR_SCHEDULER -- requirements
Module: collision_pair_scheduler

Interface
REQ-001 Parameter NUM_BALLS, default 4, SHALL set the number of balls scheduled; legal range 2..16.
REQ-002 Parameter BALL_SIZE, default 32, SHALL set the centre-distance threshold in pixels; overlap means dx*dx+dy*dy < BALL_SIZE*BALL_SIZE.
REQ-003 Derived: IDXW = clog2(NUM_BALLS); NPAIRS = NUM_BALLS*(NUM_BALLS-1)/2.
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 startOfFrame  in  1  one-cycle pulse starting a full pair sweep.
REQ-007 ballIdxA  out  IDXW  index of first ball of current pair.
REQ-008 ballIdxB  out  IDXW  index of second ball of current pair; always > ballIdxA while busy.
REQ-009 posXA, posYA  in  11 each  top-left position of ball ballIdxA, unsigned, valid combinationally from indices.
REQ-010 posXB, posYB  in  11 each  top-left position of ball ballIdxB, unsigned.
REQ-011 resolveReq  out  1  request to the velocity resolver to process pair (ballIdxA, ballIdxB).
REQ-012 resolveAck  in  1  resolver completion, one-cycle pulse.
REQ-013 collisionOccurred  out  1  one-cycle pulse per resolved collision.
REQ-014 busy  out  1  high while a sweep is in progress.
REQ-015 frameDone  out  1  one-cycle pulse when a sweep completes.
REQ-016 frameOverrun  out  1  one-cycle pulse when startOfFrame arrives while busy.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EVAL, REQUEST, NEXT.
REQ-018 IDLE: on startOfFrame, load ballIdxA=0, ballIdxB=1, pairIdx=0, go FETCH; busy=1 from next cycle.
REQ-019 FETCH (1 cycle): register dx = posXB-posXA and dy = posYB-posYA as 12-bit signed (operands zero-extended); go EVAL.
REQ-020 EVAL (1 cycle): d2 = dx*dx+dy*dy, 24-bit unsigned, no truncation; overlap = d2 < BALL_SIZE^2.
REQ-021 EVAL, overlap and contact[pairIdx]=0: set contact[pairIdx], go REQUEST.
REQ-022 EVAL, overlap and contact[pairIdx]=1: no request (pair still touching), go NEXT.
REQ-023 EVAL, no overlap: clear contact[pairIdx], go NEXT.
REQ-024 REQUEST: resolveReq=1 and indices held stable until resolveAck sampled high; then resolveReq=0, collisionOccurred=1 for the following single cycle, go NEXT.
REQ-025 resolveAck outside REQUEST SHALL be ignored.
REQ-026 NEXT: pairIdx++; if ballIdxB<NUM_BALLS-1 then ballIdxB++; else ballIdxA++, ballIdxB=ballIdxA+1 (new value); if the finished pair was (NUM_BALLS-2, NUM_BALLS-1), go IDLE, pulse frameDone, busy=0, indices return to 0.
REQ-027 Non-colliding pair costs exactly 3 cycles (FETCH, EVAL, NEXT); colliding pair costs 3 + cycles in REQUEST.
REQ-028 startOfFrame while not IDLE SHALL be ignored for scheduling and SHALL pulse frameOverrun the next cycle; sweep continues.
REQ-029 startOfFrame coinciding with a frameDone cycle (FSM in IDLE) SHALL start a new sweep normally.
REQ-030 contact bitmap (NPAIRS bits) SHALL persist across sweeps; only REQ-021/023 modify it.
REQ-031 dx or dy equal to 0 in both axes (coincident balls) counts as overlap.

Reset
REQ-032 resetN low SHALL immediately force IDLE, ballIdxA=ballIdxB=0, pairIdx=0, contact=0, resolveReq=0, collisionOccurred=0, busy=0, frameDone=0, frameOverrun=0, dx=dy=0.
REQ-033 Reset during REQUEST SHALL drop resolveReq asynchronously; no collisionOccurred pulse follows.
REQ-034 After resetN release, no activity until the next startOfFrame.

Verification
REQ-035 NUM_BALLS=4, all balls 100 px apart, startOfFrame -> pairs (0,1)(0,2)(0,3)(1,2)(1,3)(2,3) in order, no resolveReq, frameDone 18 cycles after busy rises.
REQ-036 Balls 0,1 at (100,100),(120,100), ack 2 cycles after req -> one resolveReq on (0,1), one collisionOccurred, sweep = 20 cycles.
REQ-037 Same positions, second sweep -> no resolveReq (contact set); move ball 1 to (200,100), sweep, move back, sweep -> resolveReq again.
REQ-038 Boundary: dx=32, dy=0 -> no overlap; dx=31, dy=0 -> overlap; dx=-31 -> overlap.
REQ-039 startOfFrame pulsed mid-sweep -> frameOverrun one pulse, pair sequence unchanged, single frameDone.
REQ-040 resetN asserted while resolveReq=1 -> resolveReq, busy 0 immediately, contact cleared, no collisionOccurred.

Source files
------------

// File: rtl/collision_pair_scheduler_if.sv
// collision_pair_scheduler_if: frame control, pair indices/positions and resolver handshake.
interface collision_pair_scheduler_if #(parameter int NUM_BALLS = 4);
    localparam int IDXW = $clog2(NUM_BALLS);
    logic            startOfFrame;
    logic [IDXW-1:0] ballIdxA;
    logic [IDXW-1:0] ballIdxB;
    logic [10:0]     posXA;
    logic [10:0]     posYA;
    logic [10:0]     posXB;
    logic [10:0]     posYB;
    logic            resolveReq;
    logic            resolveAck;
    logic            collisionOccurred;
    logic            busy;
    logic            frameDone;
    logic            frameOverrun;
    modport slave (
        input  startOfFrame, posXA, posYA, posXB, posYB, resolveAck,
        output ballIdxA, ballIdxB, resolveReq, collisionOccurred, busy, frameDone, frameOverrun
    );
    modport master (
        output startOfFrame, posXA, posYA, posXB, posYB, resolveAck,
        input  ballIdxA, ballIdxB, resolveReq, collisionOccurred, busy, frameDone, frameOverrun
    );
endinterface

// File: rtl/collision_pair_scheduler.sv
// collision_pair_scheduler: walks every ball pair once per frame and requests resolution on new contacts.
module collision_pair_scheduler #(
    parameter int NUM_BALLS = 4,
    parameter int BALL_SIZE = 32
) (
    input logic clk,
    input logic resetN,
    collision_pair_scheduler_if.slave bus
);
    localparam int IDXW = $clog2(NUM_BALLS);
    localparam int NPAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
    localparam int PW = $clog2(NPAIRS + 1);
    localparam logic [23:0] THRESH = 24'(BALL_SIZE * BALL_SIZE);
    typedef enum logic [2:0] {IDLE, FETCH, EVAL, REQUEST, NEXT} state_t;
    state_t state_q, state_d;
    logic [IDXW-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [NPAIRS-1:0] contact_q, contact_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d;
    logic coll_q, coll_d, done_q, done_d, ovr_q, ovr_d;
    logic signed [23:0] dx2, dy2;
    logic [23:0] d2;
    logic overlap, last_pair;
    // Squares are formed at full 24-bit width so far-apart balls never alias into overlap.
    assign dx2 = 24'(dx_q) * 24'(dx_q);
    assign dy2 = 24'(dy_q) * 24'(dy_q);
    assign d2 = dx2 + dy2;
    assign overlap = d2 < THRESH;
    assign last_pair = (a_q == IDXW'(NUM_BALLS - 2)) && (b_q == IDXW'(NUM_BALLS - 1));
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            pair_q    <= '0;
            contact_q <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            coll_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pair_q    <= pair_d;
            contact_q <= contact_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            coll_q    <= coll_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        pair_d    = pair_q;
        contact_d = contact_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        coll_d    = 1'b0;
        done_d    = 1'b0;
        ovr_d     = bus.startOfFrame && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.startOfFrame) begin
                    a_d     = '0;
                    b_d     = IDXW'(1);
                    pair_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                dx_d    = {1'b0, bus.posXB} - {1'b0, bus.posXA};
                dy_d    = {1'b0, bus.posYB} - {1'b0, bus.posYA};
                state_d = EVAL;
            end
            EVAL: begin
                // Only the first frame of a contact raises a request; a lasting touch stays quiet.
                contact_d[pair_q] = overlap;
                state_d = (overlap && !contact_q[pair_q]) ? REQUEST : NEXT;
            end
            REQUEST: begin
                coll_d  = bus.resolveAck;
                state_d = bus.resolveAck ? NEXT : REQUEST;
            end
            NEXT: begin
                pair_d = pair_q + PW'(1);
                if (last_pair) begin
                    a_d     = '0;
                    b_d     = '0;
                    pair_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    a_d     = (b_q != IDXW'(NUM_BALLS - 1)) ? a_q : a_q + IDXW'(1);
                    b_d     = (b_q != IDXW'(NUM_BALLS - 1)) ? b_q + IDXW'(1) : a_q + IDXW'(2);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.ballIdxA          = a_q;
    assign bus.ballIdxB          = b_q;
    assign bus.resolveReq        = state_q == REQUEST;
    assign bus.busy              = state_q != IDLE;
    assign bus.collisionOccurred = coll_q;
    assign bus.frameDone         = done_q;
    assign bus.frameOverrun      = ovr_q;
endmodule

// File: tb/tb_collision_pair_scheduler.sv
// tb_collision_pair_scheduler: scenario tasks checked against a pair-sweep reference model.
module tb_collision_pair_scheduler;
    localparam int NB = 4;
    localparam int BS = 32;
    localparam int NP = NB * (NB - 1) / 2;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic [10:0] px [NB];
    logic [10:0] py [NB];
    bit mc [NP];
    int errors = 0;
    int checks = 0;
    collision_pair_scheduler_if #(.NUM_BALLS(NB)) bus ();
    collision_pair_scheduler #(.NUM_BALLS(NB), .BALL_SIZE(BS)) dut (.clk(clk), .resetN(resetN), .bus(bus));
    always #5 clk = ~clk;
    always_comb begin
        bus.posXA = px[bus.ballIdxA];
        bus.posYA = py[bus.ballIdxA];
        bus.posXB = px[bus.ballIdxB];
        bus.posYB = py[bus.ballIdxB];
    end
    task automatic set_ball(input int i, input int x, input int y);
        px[i] = 11'(x);
        py[i] = 11'(y);
    endtask
    task automatic do_reset();
        resetN = 1'b0;
        for (int p = 0; p < NP; p++) mc[p] = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask
    // One full sweep: model predicts pair order, requests, contact bitmap and busy length.
    task automatic sweep(input int k, input int ov_at, input bit chain, input bit pre, input string tag);
        int ea[$], eb[$], ga[$], gb[$], xa[$], xb[$], ra[$], rb[$];
        int p = 0, exp_req = 0, exp_cyc, busy_cnt = 0, req_cyc = 0, coll_cnt = 0;
        int ov_cnt = 0, done_cnt = 0, bad = 0, guard = 0, la = -1, lb = -1;
        bit done_seen = 0, mism;
        for (int a = 0; a < NB; a++) begin
            for (int b = a + 1; b < NB; b++) begin
                int dx = int'(px[b]) - int'(px[a]);
                int dy = int'(py[b]) - int'(py[a]);
                ea.push_back(a);
                eb.push_back(b);
                if (dx * dx + dy * dy < BS * BS) begin
                    if (!mc[p]) begin
                        exp_req++;
                        xa.push_back(a);
                        xb.push_back(b);
                    end
                    mc[p] = 1'b1;
                end else mc[p] = 1'b0;
                p++;
            end
        end
        exp_cyc = 3 * NP + exp_req * k;
        if (!pre) begin
            @(negedge clk);
            bus.startOfFrame = 1'b1;
        end
        while (!done_seen && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (bus.busy) begin
                busy_cnt++;
                if (int'(bus.ballIdxA) != la || int'(bus.ballIdxB) != lb) begin
                    ga.push_back(int'(bus.ballIdxA));
                    gb.push_back(int'(bus.ballIdxB));
                end
                la = int'(bus.ballIdxA);
                lb = int'(bus.ballIdxB);
                if (bus.ballIdxB <= bus.ballIdxA) bad++;
            end
            if (bus.collisionOccurred) begin
                coll_cnt++;
                if (!bus.resolveAck) bad++;
            end
            if (bus.frameOverrun) ov_cnt++;
            if (bus.frameDone) begin
                done_cnt++;
                done_seen = 1;
                if (bus.busy) bad++;
            end
            if (bus.resolveReq) begin
                if (req_cyc == 0) begin
                    ra.push_back(int'(bus.ballIdxA));
                    rb.push_back(int'(bus.ballIdxB));
                end
                req_cyc++;
            end else req_cyc = 0;
            bus.resolveAck = bus.resolveReq && (req_cyc == k);
            bus.startOfFrame = (chain && done_seen) || (ov_at != 0 && busy_cnt == ov_at && bus.busy);
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s timeout: frameDone never seen within %0d cycles", tag, guard);
        end
        if (!chain) begin
            repeat (3) begin
                @(negedge clk);
                if (bus.frameDone) done_cnt++;
                if (bus.busy || bus.collisionOccurred || bus.resolveReq) bad++;
                if (bus.frameOverrun) ov_cnt++;
            end
        end
        checks++;
        if (busy_cnt !== exp_cyc) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, exp_cyc);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s frameDone_pulses: got %0d expected 1", tag, done_cnt);
        end
        checks++;
        if (ov_cnt !== (ov_at != 0 ? 1 : 0)) begin
            errors++;
            $display("FAIL %s frameOverrun_pulses: got %0d expected %0d", tag, ov_cnt, ov_at != 0 ? 1 : 0);
        end
        checks++;
        if (coll_cnt !== exp_req) begin
            errors++;
            $display("FAIL %s collisionOccurred_pulses: got %0d expected %0d", tag, coll_cnt, exp_req);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s protocol_violations: got %0d expected 0", tag, bad);
        end
        mism = ga.size() != ea.size();
        for (int i = 0; i < ga.size() && !mism; i++) mism = (ga[i] != ea[i]) || (gb[i] != eb[i]);
        checks++;
        if (mism) begin
            errors++;
            $display("FAIL %s pair_sequence: got %0d pairs expected %0d in order (0,1)..(%0d,%0d)", tag, ga.size(), ea.size(), NB - 2, NB - 1);
        end
        mism = ra.size() != xa.size();
        for (int i = 0; i < ra.size() && !mism; i++) mism = (ra[i] != xa[i]) || (rb[i] != xb[i]);
        checks++;
        if (mism) begin
            errors++;
            $display("FAIL %s request_pairs: got %0d requests expected %0d (first expected (%0d,%0d))", tag, ra.size(), xa.size(), xa.size() ? xa[0] : -1, xb.size() ? xb[0] : -1);
        end
    endtask
    task automatic check_idle(input string tag);
        checks++;
        if (bus.busy !== 1'b0 || bus.resolveReq !== 1'b0 || bus.collisionOccurred !== 1'b0 || bus.frameDone !== 1'b0 ||
            bus.frameOverrun !== 1'b0 || bus.ballIdxA !== '0 || bus.ballIdxB !== '0) begin
            errors++;
            $display("FAIL %s idle_outputs: busy=%b req=%b coll=%b done=%b ovr=%b a=%0d b=%0d expected all 0",
                     tag, bus.busy, bus.resolveReq, bus.collisionOccurred, bus.frameDone, bus.frameOverrun, bus.ballIdxA, bus.ballIdxB);
        end
    endtask
    task automatic test_reset();
        #1 check_idle("reset_held");
        do_reset();
        repeat (5) @(negedge clk);
        check_idle("after_release");
    endtask
    task automatic test_no_collision();
        for (int i = 0; i < NB; i++) set_ball(i, 100 + 100 * i, 100 + 100 * i);
        sweep(1, 0, 0, 0, "no_collision");
    endtask
    task automatic test_collision_pair();
        set_ball(0, 100, 100);
        set_ball(1, 120, 100);
        set_ball(2, 600, 400);
        set_ball(3, 1200, 900);
        sweep(2, 0, 0, 0, "one_collision");
    endtask
    task automatic test_contact_persist();
        sweep(2, 0, 0, 0, "still_touching");
        set_ball(1, 200, 100);
        sweep(1, 0, 0, 0, "separated");
        set_ball(1, 120, 100);
        sweep(3, 0, 0, 0, "touch_again");
    endtask
    task automatic test_boundary();
        set_ball(0, 100, 100);
        set_ball(2, 2047, 2047);
        set_ball(3, 0, 0);
        set_ball(1, 132, 100);
        sweep(1, 0, 0, 0, "dx_32");
        set_ball(1, 131, 100);
        sweep(1, 0, 0, 0, "dx_31");
        set_ball(1, 300, 100);
        sweep(1, 0, 0, 0, "apart_1");
        set_ball(1, 69, 100);
        sweep(1, 0, 0, 0, "dx_minus_31");
        set_ball(1, 100, 132);
        sweep(1, 0, 0, 0, "dy_32");
        set_ball(1, 100, 100);
        sweep(2, 0, 0, 0, "coincident");
    endtask
    task automatic test_overrun();
        set_ball(1, 400, 300);
        sweep(1, 4, 0, 0, "overrun_early");
        set_ball(1, 110, 90);
        sweep(2, 9, 0, 0, "overrun_with_req");
    endtask
    task automatic test_back_to_back();
        set_ball(1, 500, 500);
        sweep(1, 0, 1, 0, "chain_first");
        set_ball(1, 105, 105);
        sweep(1, 0, 0, 1, "chain_second");
    endtask
    task automatic test_reset_in_request();
        int guard = 0;
        do_reset();
        set_ball(0, 100, 100);
        set_ball(1, 110, 100);
        set_ball(2, 700, 100);
        set_ball(3, 1400, 100);
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        while (!bus.resolveReq && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!bus.resolveReq) begin
            errors++;
            $display("FAIL rst_in_req wait_req: resolveReq=%b expected 1 within 20 cycles", bus.resolveReq);
        end
        #2 resetN = 1'b0;
        for (int p = 0; p < NP; p++) mc[p] = 1'b0;
        #1 check_idle("rst_in_req_async");
        repeat (3) @(negedge clk);
        check_idle("rst_in_req_held");
        resetN = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("rst_in_req_release");
        sweep(1, 0, 0, 0, "after_rst_contact_clear");
    endtask
    task automatic test_random();
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < NB; i++) set_ball(i, int'($urandom_range(0, 90)), int'($urandom_range(0, 90)));
            sweep(int'($urandom_range(1, 4)), $urandom_range(0, 1) ? int'($urandom_range(2, 10)) : 0, 0, 0, $sformatf("random_%0d", s));
        end
    endtask
    initial begin
        bus.startOfFrame = 1'b0;
        bus.resolveAck = 1'b0;
        for (int i = 0; i < NB; i++) set_ball(i, 0, 0);
        test_reset();
        test_no_collision();
        test_collision_pair();
        test_contact_persist();
        test_boundary();
        test_overrun();
        test_back_to_back();
        test_reset_in_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
